// File: rtl/tb_cmd_pkg.sv
// Shared types for the scenario command dispatcher: command ids, target map, FSM states.
package tb_cmd_pkg;

  localparam int unsigned CMD_W     = 4;
  localparam int unsigned N_TARGETS = 4;
  localparam int unsigned TGT_W     = 2;
  localparam int unsigned ARG_CHARS = 16;
  localparam int unsigned ARG_W     = 8 * ARG_CHARS;

  // One argument string, right-justified ASCII; all-zero is the empty string.
  typedef logic [ARG_W-1:0] arg_t;

  typedef enum logic [CMD_W-1:0] {
    WAIT_EVENT = 4'd1,
    SET_INJ    = 4'd2,
    CHK_LEVEL  = 4'd3,
    NOP_WAIT   = 4'd4
  } cmd_id_t;

  typedef struct packed {
    logic             valid;
    logic [TGT_W-1:0] idx;
  } tgt_map_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  function automatic tgt_map_t cmd_to_target(input cmd_id_t id);
    tgt_map_t m;
    m = '0;
    case (id)
      WAIT_EVENT: m = '{valid: 1'b1, idx: TGT_W'(0)};
      SET_INJ:    m = '{valid: 1'b1, idx: TGT_W'(1)};
      CHK_LEVEL:  m = '{valid: 1'b1, idx: TGT_W'(2)};
      NOP_WAIT:   m = '{valid: 1'b1, idx: TGT_W'(3)};
      default:    m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tb_timeout_cnt.sv
// Saturating wait counter; flags the cycle whose increment reaches a nonzero limit.
module tb_timeout_cnt #(
  parameter int unsigned TO_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic [TO_W-1:0] i_limit,
  output logic            o_expired_c
);

  logic [TO_W-1:0] r_count;
  logic [TO_W-1:0] w_next;

  assign w_next      = (r_count == '1) ? r_count : r_count + TO_W'(1);
  assign o_expired_c = i_en && (i_limit != '0) && (w_next == i_limit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_next;
    end
  end

endmodule

// File: rtl/tb_cmd_dispatcher.sv
// Routes one scenario command to a single target, waits for its done or a timeout, reports status.
module tb_cmd_dispatcher
  import tb_cmd_pkg::*;
#(
  parameter int unsigned ARGS_NB   = 5,
  parameter int unsigned TARGET_NB = N_TARGETS,
  parameter int unsigned TO_W      = 32,
  parameter int unsigned ERR_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  cmd_id_t                 i_cmd_id,
  input  arg_t [ARGS_NB-1:0]      i_args,
  input  logic [TO_W-1:0]         i_timeout_cycles,
  output logic [TARGET_NB-1:0]    o_sel,
  output logic                    o_args_valid,
  output arg_t [ARGS_NB-1:0]      o_args,
  input  logic [TARGET_NB-1:0]    i_done,
  output logic                    o_cmd_done,
  output logic                    o_timeout,
  output logic                    o_err_unknown,
  output logic [ERR_W-1:0]        o_err_cnt
);

  state_t                 r_state, w_state_nxt;
  logic                   r_ready, w_ready_nxt;
  logic [TARGET_NB-1:0]   r_sel, w_sel_nxt;
  logic                   r_args_valid, w_args_valid_nxt;
  arg_t [ARGS_NB-1:0]     r_args, w_args_nxt;
  logic [TO_W-1:0]        r_limit, w_limit_nxt;
  logic                   r_cmd_done, w_cmd_done_nxt;
  logic                   r_timeout, w_timeout_nxt;
  logic                   r_err_unknown, w_err_unknown_nxt;
  logic [ERR_W-1:0]       r_err_cnt, w_err_cnt_nxt;

  tgt_map_t               w_map;
  logic                   w_hit;
  logic                   w_expired;
  logic                   w_cnt_clr;
  logic                   w_cnt_en;
  logic                   w_err_inc;

  assign w_map = cmd_to_target(i_cmd_id);
  // Only the selected target's done counts; others are ignored silently.
  assign w_hit = |(i_done & r_sel);

  tb_timeout_cnt #(.TO_W(TO_W)) u_timeout_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_cnt_clr),
    .i_en        (w_cnt_en),
    .i_limit     (r_limit),
    .o_expired_c (w_expired)
  );

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_ready_nxt       = r_ready;
    w_sel_nxt         = r_sel;
    w_args_valid_nxt  = 1'b0;
    w_args_nxt        = r_args;
    w_limit_nxt       = r_limit;
    w_cmd_done_nxt    = 1'b0;
    w_timeout_nxt     = 1'b0;
    w_err_unknown_nxt = 1'b0;
    w_cnt_clr         = 1'b0;
    w_cnt_en          = 1'b0;
    w_err_inc         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_ready_nxt = 1'b1;
        if (i_cmd_valid && r_ready) begin
          w_args_nxt  = i_args;
          w_limit_nxt = i_timeout_cycles;
          if (w_map.valid) begin
            w_state_nxt      = ST_ISSUE;
            w_ready_nxt      = 1'b0;
            w_sel_nxt        = TARGET_NB'(1) << w_map.idx;
            w_args_valid_nxt = 1'b1;
          end else begin
            w_err_unknown_nxt = 1'b1;
            w_err_inc         = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_cnt_en = 1'b1;
        // Done takes priority over a timeout landing in the same cycle.
        if (w_hit) begin
          w_cmd_done_nxt = 1'b1;
          w_sel_nxt      = '0;
          w_ready_nxt    = 1'b1;
          w_state_nxt    = ST_IDLE;
        end else if (w_expired) begin
          w_timeout_nxt = 1'b1;
          w_err_inc     = 1'b1;
          w_sel_nxt     = '0;
          w_ready_nxt   = 1'b1;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ready_nxt = 1'b1;
        w_sel_nxt   = '0;
      end
    endcase

    w_err_cnt_nxt = (w_err_inc && (r_err_cnt != '1)) ? r_err_cnt + ERR_W'(1) : r_err_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_ready       <= 1'b1;
      r_sel         <= '0;
      r_args_valid  <= 1'b0;
      r_args        <= '0;
      r_limit       <= '0;
      r_cmd_done    <= 1'b0;
      r_timeout     <= 1'b0;
      r_err_unknown <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_ready       <= w_ready_nxt;
      r_sel         <= w_sel_nxt;
      r_args_valid  <= w_args_valid_nxt;
      r_args        <= w_args_nxt;
      r_limit       <= w_limit_nxt;
      r_cmd_done    <= w_cmd_done_nxt;
      r_timeout     <= w_timeout_nxt;
      r_err_unknown <= w_err_unknown_nxt;
      r_err_cnt     <= w_err_cnt_nxt;
    end
  end

  assign o_cmd_ready   = r_ready;
  assign o_sel         = r_sel;
  assign o_args_valid  = r_args_valid;
  assign o_args        = r_args;
  assign o_cmd_done    = r_cmd_done;
  assign o_timeout     = r_timeout;
  assign o_err_unknown = r_err_unknown;
  assign o_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_tb_cmd_dispatcher.sv
// Directed bench for tb_cmd_dispatcher: vector table plus hand-written multi-cycle sequences.
module tb_tb_cmd_dispatcher;
  import tb_cmd_pkg::*;

  localparam int unsigned ARGS_NB   = 5;
  localparam int unsigned TARGET_NB = 4;
  localparam int unsigned TO_W      = 32;
  localparam int unsigned ERR_W     = 8;

  localparam int K_DONE = 0;
  localparam int K_TO   = 1;
  localparam int K_UNK  = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 i_cmd_valid;
  logic                 o_cmd_ready;
  cmd_id_t              i_cmd_id;
  arg_t [ARGS_NB-1:0]   i_args;
  logic [TO_W-1:0]      i_timeout_cycles;
  logic [TARGET_NB-1:0] o_sel;
  logic                 o_args_valid;
  arg_t [ARGS_NB-1:0]   o_args;
  logic [TARGET_NB-1:0] i_done;
  logic                 o_cmd_done;
  logic                 o_timeout;
  logic                 o_err_unknown;
  logic [ERR_W-1:0]     o_err_cnt;

  tb_cmd_dispatcher #(
    .ARGS_NB(ARGS_NB), .TARGET_NB(TARGET_NB), .TO_W(TO_W), .ERR_W(ERR_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_cmd_valid      (i_cmd_valid),
    .o_cmd_ready      (o_cmd_ready),
    .i_cmd_id         (i_cmd_id),
    .i_args           (i_args),
    .i_timeout_cycles (i_timeout_cycles),
    .o_sel            (o_sel),
    .o_args_valid     (o_args_valid),
    .o_args           (o_args),
    .i_done           (i_done),
    .o_cmd_done       (o_cmd_done),
    .o_timeout        (o_timeout),
    .o_err_unknown    (o_err_unknown),
    .o_err_cnt        (o_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    cmd_id_t    id;
    logic [31:0] to;
    int         dly;     // cycle after args_valid in which i_done is driven; -1 = never
    logic [3:0] mask;
    logic [3:0] exp_sel;
    int         kind;
    int         exp_lat; // cycles from args_valid to the status pulse
    int         exp_err;
  } vec_t;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic arg_t [ARGS_NB-1:0] mk_args(input int idx);
    arg_t [ARGS_NB-1:0] a;
    logic [7:0] b;
    b = idx[7:0];
    for (int i = 0; i < ARGS_NB; i++) a[i] = ARG_W'({8'h61 + b, 8'h30 + 8'(i)});
    return a;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, o_cmd_ready, 1);
    chk({tag, "_sel"}, o_sel, 0);
    chk({tag, "_av"}, o_args_valid, 0);
    chk({tag, "_args"}, o_args, 0);
    chk({tag, "_done"}, o_cmd_done, 0);
    chk({tag, "_to"}, o_timeout, 0);
    chk({tag, "_unk"}, o_err_unknown, 0);
    chk({tag, "_err"}, o_err_cnt, 0);
  endtask

  // Entered and left at #1 after an edge, with the DUT idle.
  task automatic run_cmd(input vec_t v, input int idx);
    arg_t [ARGS_NB-1:0] a;
    int lat;
    int bad_ready;
    int bad_av;
    a = mk_args(idx);
    chk($sformatf("v%0d_ready_idle", idx), o_cmd_ready, 1);
    i_cmd_valid      = 1'b1;
    i_cmd_id         = v.id;
    i_args           = a;
    i_timeout_cycles = v.to;
    step();
    i_cmd_valid = 1'b0;
    i_args      = ~a;
    if (v.kind == K_UNK) begin
      chk($sformatf("v%0d_unk_pulse", idx), o_err_unknown, 1);
      chk($sformatf("v%0d_unk_sel", idx), o_sel, 0);
      chk($sformatf("v%0d_unk_av", idx), o_args_valid, 0);
      chk($sformatf("v%0d_unk_ready", idx), o_cmd_ready, 1);
      chk($sformatf("v%0d_unk_done", idx), {o_cmd_done, o_timeout}, 0);
      chk($sformatf("v%0d_err", idx), o_err_cnt, v.exp_err);
      return;
    end
    chk($sformatf("v%0d_av", idx), o_args_valid, 1);
    chk($sformatf("v%0d_sel", idx), o_sel, v.exp_sel);
    chk($sformatf("v%0d_ready_busy", idx), o_cmd_ready, 0);
    chk($sformatf("v%0d_no_stale_pulse", idx), {o_cmd_done, o_timeout, o_err_unknown}, 0);
    chk($sformatf("v%0d_args", idx), o_args, a);
    lat = -1;
    bad_ready = 0;
    bad_av = 0;
    for (int t = 1; t <= 1200; t++) begin
      step();
      i_done = '0;
      if (o_cmd_done || o_timeout || o_err_unknown) begin
        lat = t;
        break;
      end
      if (o_cmd_ready !== 1'b0) bad_ready++;
      if (o_args_valid !== 1'b0) bad_av++;
      if (o_sel !== v.exp_sel) bad_av++;
      if (t == v.dly) i_done = v.mask;
    end
    i_done = '0;
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_done_pulse", idx), o_cmd_done, (v.kind == K_DONE) ? 1 : 0);
    chk($sformatf("v%0d_to_pulse", idx), o_timeout, (v.kind == K_TO) ? 1 : 0);
    chk($sformatf("v%0d_unk_quiet", idx), o_err_unknown, 0);
    chk($sformatf("v%0d_sel_clear", idx), o_sel, 0);
    chk($sformatf("v%0d_ready_back", idx), o_cmd_ready, 1);
    chk($sformatf("v%0d_err", idx), o_err_cnt, v.exp_err);
    chk($sformatf("v%0d_args_held", idx), o_args, a);
    chk($sformatf("v%0d_wait_ready_av_sel", idx), bad_ready + bad_av, 0);
  endtask

  vec_t tbl[10];

  initial begin
    arg_t [ARGS_NB-1:0] xa;
    arg_t [ARGS_NB-1:0] xb;
    int done_at;
    int av_at;
    int bad;

    tbl[0] = '{WAIT_EVENT, 32'd100, 5, 4'b0001, 4'b0001, K_DONE, 6, 0};
    tbl[1] = '{CHK_LEVEL, 32'd10, -1, 4'b0000, 4'b0100, K_TO, 11, 1};
    tbl[2] = '{cmd_id_t'(4'hF), 32'd10, -1, 4'b0000, 4'b0000, K_UNK, 0, 2};
    tbl[3] = '{SET_INJ, 32'd10, 10, 4'b0010, 4'b0010, K_DONE, 11, 2};
    tbl[4] = '{CHK_LEVEL, 32'd10, 3, 4'b1011, 4'b0100, K_TO, 11, 3};
    tbl[5] = '{NOP_WAIT, 32'd0, 1000, 4'b1000, 4'b1000, K_DONE, 1001, 3};
    tbl[6] = '{WAIT_EVENT, 32'd0, 1, 4'b0001, 4'b0001, K_DONE, 2, 3};
    tbl[7] = '{cmd_id_t'(4'h0), 32'd5, -1, 4'b0000, 4'b0000, K_UNK, 0, 4};
    tbl[8] = '{SET_INJ, 32'd1, -1, 4'b0000, 4'b0010, K_TO, 2, 5};
    tbl[9] = '{cmd_id_t'(4'h5), 32'd5, -1, 4'b0000, 4'b0000, K_UNK, 0, 6};

    rst_n            = 1'b0;
    i_cmd_valid      = 1'b0;
    i_cmd_id         = WAIT_EVENT;
    i_args           = '0;
    i_timeout_cycles = '0;
    i_done           = '0;
    repeat (3) step();
    chk_reset("por");
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 10; k++) run_cmd(tbl[k], k);
    step();
    chk("tail_quiet", {o_cmd_done, o_timeout, o_err_unknown}, 0);

    // Next command held on valid while busy: accepted only once the first completes.
    xa = mk_args(20);
    xb = mk_args(21);
    i_cmd_valid      = 1'b1;
    i_cmd_id         = WAIT_EVENT;
    i_args           = xa;
    i_timeout_cycles = 32'd50;
    step();
    chk("hold_a_av", o_args_valid, 1);
    i_cmd_id         = CHK_LEVEL;
    i_args           = xb;
    i_timeout_cycles = 32'd12;
    done_at = -1;
    av_at   = -1;
    bad     = 0;
    for (int t = 1; t <= 8; t++) begin
      step();
      i_done = '0;
      if (o_cmd_done) done_at = t;
      if (o_args_valid) av_at = t;
      if (t < 6 && o_args !== xa) bad++;
      if (t == 4) i_done = 4'b0001;
    end
    i_cmd_valid = 1'b0;
    chk("hold_a_done_at", done_at, 5);
    chk("hold_b_av_at", av_at, 6);
    chk("hold_a_args_stable", bad, 0);
    chk("hold_b_args", o_args, xb);
    chk("hold_b_sel", o_sel, 4'b0100);
    chk("hold_b_ready", o_cmd_ready, 0);

    // Reset while B waits: everything returns to reset values, no late timeout.
    rst_n = 1'b0;
    step();
    chk_reset("midrst");
    rst_n = 1'b1;
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      step();
      if (o_cmd_done || o_timeout || o_err_unknown || o_sel != '0) bad++;
    end
    chk("midrst_no_pulse", bad, 0);
    run_cmd('{WAIT_EVENT, 32'd8, 2, 4'b0001, 4'b0001, K_DONE, 3, 0}, 30);

    // Unknown ids back to back: one per cycle, counter saturates at 255.
    i_cmd_valid = 1'b1;
    i_cmd_id    = cmd_id_t'(4'hF);
    bad = 0;
    for (int t = 0; t < 260; t++) begin
      step();
      if (o_err_unknown !== 1'b1 || o_cmd_ready !== 1'b1) bad++;
    end
    chk("sat_pulses", bad, 0);
    chk("sat_cnt", o_err_cnt, 255);
    step();
    chk("sat_hold", o_err_cnt, 255);
    i_cmd_valid = 1'b0;
    step();
    chk("sat_idle_quiet", o_err_unknown, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
